// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Build option: define BNE_EN to add bne (opcode 0x05) to the dispatch table.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned SEL_W   = 2;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OPC_W-1:0] FN_SLL = 6'h00;
  localparam logic [OPC_W-1:0] FN_SRL = 6'h02;
  localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
  localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
  localparam logic [OPC_W-1:0] FN_AND = 6'h24;
  localparam logic [OPC_W-1:0] FN_OR  = 6'h25;
  localparam logic [OPC_W-1:0] FN_NOR = 6'h27;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_SEXT = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_ZEXT = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
  } state_t;

  // State entered after DECODE; S_FETCH means the opcode is unsupported.
  function automatic state_t dispatch(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_LW, OP_SW:                     dispatch = S_MEMADDR;
      OP_RTYPE:                         dispatch = S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: dispatch = S_EXEC_I;
      OP_BEQ:                           dispatch = S_BRANCH;
`ifdef BNE_EN
      OP_BNE:                           dispatch = S_BRANCH;
`endif
      OP_J:                             dispatch = S_JUMP;
      default:                          dispatch = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation / operand-B select / illegal-instruction decode
// for each control state.
module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [STATE_W-1:0]  state,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [OPC_W-1:0]    funct,
  output logic [ALU_OP_W-1:0] alu_operation_c,
  output logic [SEL_W-1:0]    alu_src_b_c,
  output logic                illegal_op_c
);

  always_comb begin
    alu_operation_c = '0;
    alu_src_b_c     = SRCB_REG;
    illegal_op_c    = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        alu_operation_c = ALU_OP_W'(ALU_ADD);
        alu_src_b_c     = SRCB_FOUR;
      end
      // Branch target precompute: the datapath applies the word shift to this operand.
      S_DECODE: begin
        alu_operation_c = ALU_OP_W'(ALU_ADD);
        alu_src_b_c     = SRCB_SEXT;
        illegal_op_c    = (dispatch(opcode) == S_FETCH);
      end
      S_MEMADDR: begin
        alu_operation_c = ALU_OP_W'(ALU_ADD);
        alu_src_b_c     = SRCB_SEXT;
      end
      S_EXEC_R: begin
        case (funct)
          FN_ADD:  alu_operation_c = ALU_OP_W'(ALU_ADD);
          FN_SUB:  alu_operation_c = ALU_OP_W'(ALU_SUB);
          FN_AND:  alu_operation_c = ALU_OP_W'(ALU_AND);
          FN_OR:   alu_operation_c = ALU_OP_W'(ALU_OR);
          FN_NOR:  alu_operation_c = ALU_OP_W'(ALU_NOR);
          FN_SLL:  alu_operation_c = ALU_OP_W'(ALU_SLL);
          FN_SRL:  alu_operation_c = ALU_OP_W'(ALU_SRL);
          default: illegal_op_c    = 1'b1;
        endcase
      end
      S_EXEC_I: begin
        case (opcode)
          OP_ADDI: begin
            alu_operation_c = ALU_OP_W'(ALU_ADD);
            alu_src_b_c     = SRCB_SEXT;
          end
          OP_ANDI: begin
            alu_operation_c = ALU_OP_W'(ALU_AND);
            alu_src_b_c     = SRCB_ZEXT;
          end
          OP_ORI: begin
            alu_operation_c = ALU_OP_W'(ALU_OR);
            alu_src_b_c     = SRCB_ZEXT;
          end
          OP_LUI: begin
            alu_operation_c = ALU_OP_W'(ALU_LUI);
            alu_src_b_c     = SRCB_ZEXT;
          end
          default: ;
        endcase
      end
      S_BRANCH: alu_operation_c = ALU_OP_W'(ALU_SUB);
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM driving the ALU, memory, PC and register file.
// Build option: BNE_EN enables the bne instruction (opcode 0x05).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [OPC_W-1:0]    funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    pc_source,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal_op
);

  state_t               state;
  state_t               state_nxt;
  logic [ALU_OP_W-1:0]  dec_op;
  logic [SEL_W-1:0]     dec_srcb;
  logic                 dec_ill;

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .state           (state),
    .opcode          (opcode),
    .funct           (funct),
    .alu_operation_c (dec_op),
    .alu_src_b_c     (dec_srcb),
    .illegal_op_c    (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Reset low blanks every output in the same cycle, including pending write enables.
  always_comb begin
    state_nxt     = state;
    alu_operation = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    pc_en         = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    if (reset) begin
      alu_operation = dec_op;
      alu_src_b     = dec_srcb;
      illegal_op    = dec_ill;
      case (state)
        S_IDLE: state_nxt = S_FETCH;
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_en    = mem_ready;
          if (mem_ready) state_nxt = S_DECODE;
        end
        S_DECODE: state_nxt = dispatch(opcode);
        S_MEMADDR: begin
          alu_src_a = 1'b1;
          state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEMWRITE: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) state_nxt = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          state_nxt = dec_ill ? S_FETCH : S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          state_nxt = S_ALU_WB;
        end
        // IR is stable for the whole instruction, so the opcode identifies the R-type path.
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE);
          state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_source = PCSRC_ALUOUT;
          pc_en     = (opcode == OP_BNE) ? ~zero : zero;
          state_nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_source = PCSRC_JUMP;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, bne sequence,
// and randomized instruction stream against a per-instruction schedule model.
module tb_multicycle_control;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_NOR = 4'd2, A_ADD = 4'd3;
  localparam logic [3:0] A_SUB = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_LUI = 4'd7;

  typedef struct packed {
    logic [3:0] op;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pe, iod, mrd, mwr, irw, rd, m2r, rw, ill;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       zr;
    logic       mr;
    outs_t      e;
    string      name;
  } vec_t;

  typedef enum int {K_PLAIN, K_FETCH, K_WAIT, K_BEQ, K_BNE} kind_t;
  typedef struct {
    kind_t k;
    outs_t e;
    string name;
  } step_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic [3:0] alu_operation;
  logic alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op;

  int unsigned checks = 0;
  int unsigned passed = 0;
  vec_t  vecs[$];
  step_t sched[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_operation(alu_operation), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Expected output bundles per step of an instruction.
  function automatic outs_t e_fetch(input logic mr);
    outs_t e = '0;
    e.op = A_ADD; e.sb = 2'd1; e.mrd = 1'b1; e.pe = mr; e.irw = mr;
    return e;
  endfunction
  function automatic outs_t e_decode(input logic ill);
    outs_t e = '0;
    e.op = A_ADD; e.sb = 2'd2; e.ill = ill;
    return e;
  endfunction
  function automatic outs_t e_memaddr();
    outs_t e = '0;
    e.op = A_ADD; e.sa = 1'b1; e.sb = 2'd2;
    return e;
  endfunction
  function automatic outs_t e_mem(input logic wr);
    outs_t e = '0;
    e.iod = 1'b1; e.mrd = ~wr; e.mwr = wr;
    return e;
  endfunction
  function automatic outs_t e_memwb();
    outs_t e = '0;
    e.rw = 1'b1; e.m2r = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_exec(input logic [3:0] op, input logic [1:0] sb, input logic ill);
    outs_t e = '0;
    e.op = op; e.sa = 1'b1; e.sb = sb; e.ill = ill;
    return e;
  endfunction
  function automatic outs_t e_wb(input logic rd);
    outs_t e = '0;
    e.rw = 1'b1; e.rd = rd;
    return e;
  endfunction
  function automatic outs_t e_branch(input logic pe);
    outs_t e = '0;
    e.op = A_SUB; e.sa = 1'b1; e.ps = 2'd1; e.pe = pe;
    return e;
  endfunction
  function automatic outs_t e_jump();
    outs_t e = '0;
    e.ps = 2'd2; e.pe = 1'b1;
    return e;
  endfunction

  function automatic bit opc_legal(input logic [5:0] opc);
    case (opc)
      6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
`ifdef BNE_EN
      6'h05: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit r_op(input logic [5:0] fn, output logic [3:0] op);
    op = A_AND;
    case (fn)
      6'h20: op = A_ADD;
      6'h22: op = A_SUB;
      6'h24: op = A_AND;
      6'h25: op = A_OR;
      6'h27: op = A_NOR;
      6'h00: op = A_SLL;
      6'h02: op = A_SRL;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic void push(input kind_t k, input outs_t e, input string name);
    step_t s;
    s.k = k; s.e = e; s.name = name;
    sched.push_back(s);
  endfunction

  // Reference schedule: the list of cycles an instruction occupies, from its class.
  function automatic void plan(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] op;
    sched.delete();
    push(K_FETCH, '0, "rnd_fetch");
    push(K_PLAIN, e_decode(!opc_legal(opc)), "rnd_decode");
    if (opc_legal(opc)) begin
      case (opc)
        6'h23: begin
          push(K_PLAIN, e_memaddr(), "rnd_lw_addr");
          push(K_WAIT, e_mem(1'b0), "rnd_lw_read");
          push(K_PLAIN, e_memwb(), "rnd_lw_wb");
        end
        6'h2B: begin
          push(K_PLAIN, e_memaddr(), "rnd_sw_addr");
          push(K_WAIT, e_mem(1'b1), "rnd_sw_write");
        end
        6'h00: begin
          if (r_op(fn, op)) begin
            push(K_PLAIN, e_exec(op, 2'd0, 1'b0), "rnd_exec_r");
            push(K_PLAIN, e_wb(1'b1), "rnd_wb_r");
          end else begin
            push(K_PLAIN, e_exec(A_AND, 2'd0, 1'b1), "rnd_bad_funct");
          end
        end
        6'h08: begin push(K_PLAIN, e_exec(A_ADD, 2'd2, 1'b0), "rnd_addi"); push(K_PLAIN, e_wb(1'b0), "rnd_wb_i"); end
        6'h0C: begin push(K_PLAIN, e_exec(A_AND, 2'd3, 1'b0), "rnd_andi"); push(K_PLAIN, e_wb(1'b0), "rnd_wb_i"); end
        6'h0D: begin push(K_PLAIN, e_exec(A_OR, 2'd3, 1'b0), "rnd_ori"); push(K_PLAIN, e_wb(1'b0), "rnd_wb_i"); end
        6'h0F: begin push(K_PLAIN, e_exec(A_LUI, 2'd3, 1'b0), "rnd_lui"); push(K_PLAIN, e_wb(1'b0), "rnd_wb_i"); end
        6'h04: push(K_BEQ, '0, "rnd_beq");
        6'h05: push(K_BNE, '0, "rnd_bne");
        6'h02: push(K_PLAIN, e_jump(), "rnd_jump");
        default: ;
      endcase
    end
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.op = alu_operation; a.sa = alu_src_a; a.sb = alu_src_b; a.ps = pc_source;
    a.pe = pc_en; a.iod = i_or_d; a.mrd = mem_read; a.mwr = mem_write; a.irw = ir_write;
    a.rd = reg_dst; a.m2r = mem_to_reg; a.rw = reg_write; a.ill = illegal_op;
    return a;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = actual();
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle's inputs after the falling edge, check, then move to the next falling edge.
  task automatic cycle(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                       input logic zr, input logic mr, input outs_t exp, input string name);
    reset = rst; opcode = opc; funct = fn; zero = zr; mem_ready = mr;
    #1;
    check(name, exp);
    @(negedge clk);
  endtask

  task automatic add(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                     input logic zr, input logic mr, input outs_t e, input string name);
    vec_t v;
    v.rst = rst; v.opc = opc; v.fn = fn; v.zr = zr; v.mr = mr; v.e = e; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] opcs[14];
    logic [5:0] fns[9];
    logic [5:0] opc, fn;
    logic zr, mr;
    outs_t e;
    int waits;

    opcs = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h01};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h3F, 6'h21};

    add(0, 6'h00, 6'h20, 0, 1, '0, "reset_0");
    add(0, 6'h00, 6'h20, 0, 1, '0, "reset_1");
    add(0, 6'h00, 6'h20, 0, 1, '0, "reset_2");
    add(1, 6'h00, 6'h20, 0, 1, '0, "idle");
    add(1, 6'h00, 6'h20, 0, 1, e_fetch(1), "add_fetch");
    add(1, 6'h00, 6'h20, 0, 1, e_decode(0), "add_decode");
    add(1, 6'h00, 6'h20, 0, 1, e_exec(A_ADD, 2'd0, 0), "add_exec");
    add(1, 6'h00, 6'h20, 0, 1, e_wb(1), "add_wb");
    add(1, 6'h23, 6'h00, 0, 1, e_fetch(1), "lw_fetch");
    add(1, 6'h23, 6'h00, 0, 1, e_decode(0), "lw_decode");
    add(1, 6'h23, 6'h00, 0, 1, e_memaddr(), "lw_addr");
    add(1, 6'h23, 6'h00, 0, 0, e_mem(0), "lw_wait0");
    add(1, 6'h23, 6'h00, 0, 0, e_mem(0), "lw_wait1");
    add(1, 6'h23, 6'h00, 0, 1, e_mem(0), "lw_read");
    add(1, 6'h23, 6'h00, 0, 1, e_memwb(), "lw_wb");
    add(1, 6'h04, 6'h00, 1, 1, e_fetch(1), "beq_t_fetch");
    add(1, 6'h04, 6'h00, 1, 1, e_decode(0), "beq_t_decode");
    add(1, 6'h04, 6'h00, 1, 1, e_branch(1), "beq_taken");
    add(1, 6'h04, 6'h00, 0, 1, e_fetch(1), "beq_n_fetch");
    add(1, 6'h04, 6'h00, 0, 1, e_decode(0), "beq_n_decode");
    add(1, 6'h04, 6'h00, 0, 1, e_branch(0), "beq_not_taken");
    add(1, 6'h3F, 6'h00, 0, 1, e_fetch(1), "bad_op_fetch");
    add(1, 6'h3F, 6'h00, 0, 1, e_decode(1), "bad_op_decode");
    add(1, 6'h2B, 6'h00, 0, 0, e_fetch(0), "sw_fetch_stall");
    add(1, 6'h2B, 6'h00, 0, 1, e_fetch(1), "sw_fetch");
    add(1, 6'h2B, 6'h00, 0, 1, e_decode(0), "sw_decode");
    add(1, 6'h2B, 6'h00, 0, 1, e_memaddr(), "sw_addr");
    add(0, 6'h2B, 6'h00, 0, 1, '0, "sw_reset_mid");
    add(1, 6'h2B, 6'h00, 0, 1, '0, "idle_after_reset");
    add(1, 6'h02, 6'h00, 0, 1, e_fetch(1), "j_fetch");
    add(1, 6'h02, 6'h00, 0, 1, e_decode(0), "j_decode");
    add(1, 6'h02, 6'h00, 0, 1, e_jump(), "j_jump");
    add(1, 6'h00, 6'h3F, 0, 1, e_fetch(1), "badfn_fetch");
    add(1, 6'h00, 6'h3F, 0, 1, e_decode(0), "badfn_decode");
    add(1, 6'h00, 6'h3F, 0, 1, e_exec(A_AND, 2'd0, 1), "badfn_exec");
    add(1, 6'h0F, 6'h00, 0, 1, e_fetch(1), "lui_fetch");
    add(1, 6'h0F, 6'h00, 0, 1, e_decode(0), "lui_decode");
    add(1, 6'h0F, 6'h00, 0, 1, e_exec(A_LUI, 2'd3, 0), "lui_exec");
    add(1, 6'h0F, 6'h00, 0, 1, e_wb(0), "lui_wb");

    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].rst, vecs[i].opc, vecs[i].fn, vecs[i].zr, vecs[i].mr, vecs[i].e, vecs[i].name);

    // bne: taken on zero=0 when enabled, otherwise an illegal opcode.
    cycle(1, 6'h05, 6'h00, 0, 1, e_fetch(1), "bne_fetch");
`ifdef BNE_EN
    cycle(1, 6'h05, 6'h00, 0, 1, e_decode(0), "bne_decode");
    cycle(1, 6'h05, 6'h00, 0, 1, e_branch(1), "bne_taken");
`else
    cycle(1, 6'h05, 6'h00, 0, 1, e_decode(1), "bne_illegal");
`endif

    for (int n = 0; n < 300; n++) begin
      opc = opcs[$urandom_range(0, 13)];
      fn  = fns[$urandom_range(0, 8)];
      plan(opc, fn);
      foreach (sched[j]) begin
        waits = 0;
        do begin
          zr = 1'($urandom_range(0, 1));
          mr = (waits >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          case (sched[j].k)
            K_FETCH: e = e_fetch(mr);
            K_BEQ:   e = e_branch(zr);
            K_BNE:   e = e_branch(~zr);
            default: e = sched[j].e;
          endcase
          cycle(1, opc, fn, zr, mr, e, sched[j].name);
          waits++;
        end while ((sched[j].k == K_FETCH || sched[j].k == K_WAIT) && !mr);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control FSM: the driver side of the ALU interface. It sequences fetch/decode/execute/memory/writeback and issues the 4-bit ALU operation code, operand selects and datapath enables each cycle. It consumes the ALU `Zero` flag to resolve branches. It sits between the instruction register and the datapath muxes, memory and register file of the multicycle core.

## Interface
- `ALU_OP_W`, default 4: width of the ALU operation code.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU Zero flag, same cycle as the issued operation.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_operation`  out  4  ALU code: AND=0, OR=1, NOR=2, ADD=3, SUB=4, SLL=5, SRL=6, LUI=7.
- `alu_src_a`  out  1  0=PC, 1=register A.
- `alu_src_b`  out  2  0=B, 1=constant 4, 2=sign-extended immediate, 3=zero-extended immediate.
- `pc_source`  out  2  0=ALU result, 1=ALUOut register, 2=jump target.
- `pc_en`  out  1  PC write enable (includes branch condition).
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  memory and IR controls.
- `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  register-file controls.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- Reset (`reset`=0 at an edge) forces IDLE from any state, mid-instruction included. In IDLE all outputs are 0. The next state is always FETCH.
- FETCH: `mem_read`=1, `alu_src_a`=0, `alu_src_b`=1, ADD, `pc_source`=0.
  - `ir_write` and `pc_en` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: ADD with PC + (sext imm << 2) into ALUOut.
  - Dispatch: 0x23/0x2B → MEMADDR; 0x00 → EXEC_R; 0x08/0x0C/0x0D/0x0F → EXEC_I; 0x04 → BRANCH; 0x02 → JUMP.
  - Any other opcode: `illegal_op`=1, go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0.
  - Funct 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR, 0x27 → NOR, 0x00 → SLL, 0x02 → SRL.
  - Any other funct: `illegal_op`=1, no writeback, go to FETCH.
- EXEC_I: `alu_src_a`=1. ADDI → ADD with `alu_src_b`=2; ANDI → AND, `alu_src_b`=3; ORI → OR, `alu_src_b`=3; LUI → LUI, `alu_src_b`=3.
- ALU_WB: `reg_write`=1. `reg_dst`=1 when reached from EXEC_R, else 0. `mem_to_reg`=0. Then FETCH.
- MEMADDR: ADD, `alu_src_a`=1, `alu_src_b`=2. Next state MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD and MEMWRITE: `i_or_d`=1 with `mem_read` or `mem_write`=1. Hold the state until `mem_ready`=1.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Then FETCH.
- BRANCH: SUB, `alu_src_a`=1, `alu_src_b`=0, `pc_source`=1. `pc_en` = `zero` (beq). Then FETCH.
- JUMP: `pc_source`=2, `pc_en`=1. Then FETCH.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore-decoded from the state register. Exceptions: `pc_en` and `ir_write` in FETCH follow `mem_ready`; `pc_en` in BRANCH follows `zero`. Both paths are combinational, same cycle.
- Cycle counts with no wait states: R/I-type 4, lw 5, sw 4, beq 3, j 3. Each `mem_ready`=0 cycle adds one cycle.
- `illegal_op` is high only in the one DECODE or EXEC_R cycle that detects the fault.
- `reset` low overrides a simultaneous `mem_ready` and produces no write enable that cycle.

## Configuration
- `BNE_EN` defined: opcode 0x05 dispatches to BRANCH with `pc_en` = ~`zero`.
- `BNE_EN` undefined: 0x05 is illegal (`illegal_op` pulse, return to FETCH).

## Structure
- Shared package `mips_ctrl_pkg`:
  - ALU operation localparams (AND..LUI);
  - opcode and funct constants;
  - state encoding (4-bit);
  - `alu_src_b` and `pc_source` select encodings.
- One sub-module, `alu_op_decoder`: combinational mapping of state/opcode/funct to `alu_operation`, `alu_src_b` and `illegal_op`. The FSM stays in `multicycle_control`.

## Test plan
- Reset held low 3 cycles, released with `mem_ready`=1 → all outputs 0 for those cycles; IDLE one cycle, then FETCH with `mem_read`=1, `alu_operation`=3, `pc_en`=1.
- R-type add (opcode 0x00, funct 0x20), no waits → FETCH, DECODE, EXEC_R with `alu_operation`=3, then ALU_WB with `reg_write`=1 and `reg_dst`=1; 4 cycles total.
- lw (0x23) with `mem_ready` low 2 cycles in MEMREAD → 7 cycles total; MEMWB has `mem_to_reg`=1 and `reg_write`=1.
- beq (0x04): `zero`=1 → `pc_en`=1, `pc_source`=1, `alu_operation`=4; repeat with `zero`=0 → `pc_en`=0.
- Opcode 0x3F → `illegal_op`=1 for the single DECODE cycle, then FETCH, no `reg_write`. Opcode 0x05 → taken when `zero`=0 with `BNE_EN` defined, illegal without it.
- `reset` driven low during MEMWRITE while `mem_ready`=1 → `mem_write`=0 that cycle; next state IDLE.
